// File: rtl/cdb_arbiter_pkg.sv
// Shared LC-3b type package.
// Holds the ROB tag and data word typedefs, plus the fixed CDB requester
// index map used by the execute units.
package lc3b_types;

    typedef logic [2:0]  lc3b_rob_addr;
    typedef logic [15:0] lc3b_word;

    // CDB requester slots; a unit's index is also its req/grant bit.
    localparam int NUM_CDB_REQ     = 4;
    localparam int CDB_REQ_ALU_RS  = 0;
    localparam int CDB_REQ_LDBUF   = 1;
    localparam int CDB_REQ_BRADDR  = 2;
    localparam int CDB_REQ_JSRTRAP = 3;

endpackage

// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus interface.
// master: the execute-unit side. It drives req/tag_in/value_in/flush and
//         observes grant and the broadcast.
// slave : the arbiter. It drives grant and the cdb_* broadcast register.
interface cdb_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int data_width = 16,
    parameter int tag_width  = 3
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*tag_width-1:0]  tag_in;
    logic [NUM_REQ*data_width-1:0] value_in;
    logic                          flush;
    logic [NUM_REQ-1:0]            grant;
    logic                          cdb_valid;
    logic [tag_width-1:0]          cdb_tag;
    logic [data_width-1:0]         cdb_value;

    modport master (
        output req, tag_in, value_in, flush,
        input  grant, cdb_valid, cdb_tag, cdb_value
    );

    modport slave (
        input  req, tag_in, value_in, flush,
        output grant, cdb_valid, cdb_tag, cdb_value
    );
endinterface

// File: rtl/cdb_rr_pick.sv
// Combinational rotating-priority picker.
// Searches req upward from index base, wrapping modulo NUM_REQ. The first
// set bit wins.
// Ports: req (request vector), base (start index, must be < NUM_REQ),
//        grant (one-hot winner or zero), winner (winner index),
//        any_req (some request present).
module cdb_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   base,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   winner,
    output logic               any_req
);
    always_comb begin
        grant   = '0;
        winner  = '0;
        any_req = |req;
        // Walk offsets from farthest to nearest. The closest set bit to
        // base is written last and therefore wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(base) + k) % NUM_REQ])
                winner = PTR_W'((int'(base) + k) % NUM_REQ);
        end
        if (any_req)
            grant[winner] = 1'b1;
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter.
// Grants at most one result producer per cycle using round-robin priority.
// The winner's {tag, value} is registered onto the CDB one cycle later.
// Ports: clk, rst_n (async, active low), bus (cdb_arbiter_if.slave:
//        req/tag_in/value_in/flush in, grant/cdb_valid/cdb_tag/cdb_value out).
module cdb_arbiter
    import lc3b_types::*;
#(
    parameter int NUM_REQ    = NUM_CDB_REQ,
    parameter int data_width = 16,
    parameter int tag_width  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   winner;
    logic [NUM_REQ-1:0] pick_grant;
    logic               any_req;
    logic               grant_ok;

    cdb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (bus.req),
        .base    (rr_ptr),
        .grant   (pick_grant),
        .winner  (winner),
        .any_req (any_req)
    );

    // Reset is in the grant path so a requester never sees an acknowledge
    // while reset is asserted. That transfer is simply lost.
    assign grant_ok  = rst_n && !bus.flush && any_req;
    assign bus.grant = grant_ok ? pick_grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            bus.cdb_valid <= 1'b0;
            bus.cdb_tag   <= '0;
            bus.cdb_value <= '0;
        end else begin
            // A flush cycle clears valid because grant_ok is low in it.
            bus.cdb_valid <= grant_ok;
            if (grant_ok) begin
                rr_ptr        <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                bus.cdb_tag   <= bus.tag_in[int'(winner)*tag_width +: tag_width];
                bus.cdb_value <= bus.value_in[int'(winner)*data_width +: data_width];
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int TW = 3;
    localparam int DW = 16;

    logic clk;
    logic rst_n;

    cdb_arbiter_if #(.NUM_REQ(N), .data_width(DW), .tag_width(TW)) bus ();

    cdb_arbiter #(.NUM_REQ(N), .data_width(DW), .tag_width(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pointer, broadcast register
    int          m_ptr;
    logic        m_valid;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_val;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_val = '0;
    endtask

    // Winner = the requester with the smallest forward distance from m_ptr.
    function automatic logic [N-1:0] model_grant(input logic [N-1:0] r, input logic f, input logic rs);
        int best;
        int bd;
        best = -1;
        bd   = N;
        if (f || !rs) return '0;
        for (int i = 0; i < N; i++) begin
            if (r[i] && ((i - m_ptr + N) % N) < bd) begin
                bd   = (i - m_ptr + N) % N;
                best = i;
            end
        end
        if (best < 0) return '0;
        return N'(1 << best);
    endfunction

    // Drive one cycle from a negedge and check grant before the edge. Then
    // step the model and check the broadcast after the edge. Return at the
    // next negedge.
    task automatic cycle(input logic [N-1:0] r, input logic f,
                         input logic [N*TW-1:0] t, input logic [N*DW-1:0] v,
                         input bit use_exp, input logic [N-1:0] exp_g, input string nm);
        logic [N-1:0] mg;
        int w;
        bus.req = r; bus.flush = f; bus.tag_in = t; bus.value_in = v;
        #1;
        mg = model_grant(r, f, rst_n);
        chk({nm, "_grant"}, 32'(bus.grant), 32'(mg));
        if (use_exp) chk({nm, "_grant_tbl"}, 32'(bus.grant), 32'(exp_g));
        @(posedge clk);
        m_valid = (mg != '0);
        if (mg != '0) begin
            w = 0;
            for (int i = 0; i < N; i++) if (mg[i]) w = i;
            m_tag = t[w*TW +: TW];
            m_val = v[w*DW +: DW];
            m_ptr = (w + 1) % N;
        end
        #1;
        chk({nm, "_valid"}, 32'(bus.cdb_valid), 32'(m_valid));
        chk({nm, "_tag"},   32'(bus.cdb_tag),   32'(m_tag));
        chk({nm, "_value"}, 32'(bus.cdb_value), 32'(m_val));
        @(negedge clk);
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         flush;
        logic [N-1:0] exp_grant;
    } vec_t;

    vec_t vecs[12];

    localparam logic [N*TW-1:0] TAGS = {3'd7, 3'd6, 3'd5, 3'd4};
    localparam logic [N*DW-1:0] VALS = {16'hA003, 16'hA002, 16'hA001, 16'hA000};

    initial begin
        logic [N*TW-1:0] t;
        logic [N*DW-1:0] v;

        // Fairness, then pointer skip (ptr=1 with req 1001 picks 3, then 0)
        for (int i = 0; i < 8; i++) vecs[i] = '{4'b1111, 1'b0, 4'(1 << (i % 4))};
        vecs[8]  = '{4'b0001, 1'b0, 4'b0001};
        vecs[9]  = '{4'b1001, 1'b0, 4'b1000};
        vecs[10] = '{4'b1001, 1'b0, 4'b0001};
        vecs[11] = '{4'b0000, 1'b0, 4'b0000};

        // Reset state, async grant suppression
        model_reset();
        rst_n = 1'b0;
        bus.req = 4'b1111; bus.flush = 1'b0; bus.tag_in = TAGS; bus.value_in = VALS;
        #3;
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_valid", 32'(bus.cdb_valid), 0);
        chk("rst_tag",   32'(bus.cdb_tag), 0);
        chk("rst_value", 32'(bus.cdb_value), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Table-driven fairness/pointer vectors
        for (int i = 0; i < 12; i++)
            cycle(vecs[i].req, vecs[i].flush, TAGS, VALS, 1'b1, vecs[i].exp_grant, $sformatf("tbl%0d", i));

        // Single requester
        t = '0; v = '0; t[2*TW +: TW] = 3'd5; v[2*DW +: DW] = 16'hBEEF;
        cycle(4'b0100, 1'b0, t, v, 1'b1, 4'b0100, "single");
        chk("single_tag",   32'(bus.cdb_tag), 5);
        chk("single_value", 32'(bus.cdb_value), 32'hBEEF);
        cycle(4'b0000, 1'b0, t, v, 1'b1, 4'b0000, "single_drop");
        chk("single_drop_valid", 32'(bus.cdb_valid), 0);

        // Flush: ptr=3 here; 0011 grants 0, flush blocks, then 1 wins
        cycle(4'b0011, 1'b0, TAGS, VALS, 1'b1, 4'b0001, "pre_flush");
        chk("flush_prev_visible", 32'(bus.cdb_valid), 1);
        cycle(4'b0011, 1'b1, TAGS, VALS, 1'b1, 4'b0000, "flush");
        chk("flush_valid_clr", 32'(bus.cdb_valid), 0);
        cycle(4'b0011, 1'b0, TAGS, VALS, 1'b1, 4'b0010, "post_flush");

        // Back-to-back same requester, tags 1,2,3
        for (int k = 1; k <= 3; k++) begin
            t = '0; v = '0; t[TW-1:0] = 3'(k); v[DW-1:0] = 16'(16'h1000 + k);
            cycle(4'b0001, 1'b0, t, v, 1'b1, 4'b0001, $sformatf("b2b%0d", k));
            chk($sformatf("b2b%0d_tag", k), 32'(bus.cdb_tag), 32'(k));
            chk($sformatf("b2b%0d_valid", k), 32'(bus.cdb_valid), 1);
        end

        // Async reset mid-cycle with a live broadcast and pending request
        bus.req = 4'b1111; bus.flush = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_grant", 32'(bus.grant), 0);
        chk("midrst_valid", 32'(bus.cdb_valid), 0);
        chk("midrst_tag",   32'(bus.cdb_tag), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'b1111, 1'b0, TAGS, VALS, 1'b1, 4'b0001, "postrst");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            t = N*TW'($urandom);
            v = {$urandom, $urandom};
            cycle(4'($urandom), ($urandom_range(0, 9) == 0), t, v, 1'b0, 4'b0000, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
